// File: rtl/sid_voice_wide.sv
// sid_voice_wide: parametrised SID voice. Phase accumulator with hard sync,
// sawtooth/triangle/pulse/noise generators, OR/AND waveform combine and
// envelope scaling by a sequential or single-cycle multiplier.
module sid_voice_wide #(
   parameter int ACC_W   = 24,
   parameter int FREQ_W  = 16,
   parameter int WAVE_W  = 12,
   parameter int PW_W    = 12,
   parameter int ENV_W   = 8,
   parameter int OUT_W   = 12,
   parameter int COMBINE = 0,
   parameter int MUL_PAR = 0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [FREQ_W-1:0] frequency,
   input  logic [PW_W-1:0]   pulse_width,
   input  logic [7:0]        control,
   input  logic [ENV_W-1:0]  env,
   input  logic              acc_msb_in,
   output logic              acc_msb_out,
   output logic [OUT_W-1:0]  voice,
   output logic              voice_valid
);

   localparam int PROD_W = WAVE_W + ENV_W;
   localparam int CNT_W  = $clog2(ENV_W + 1);

   logic ctl_noise, ctl_pulse, ctl_saw, ctl_tri, ctl_test, ctl_ring, ctl_sync;
   logic unused_gate;

   logic [ACC_W-1:0]  acc_q, acc_d;
   logic              msb_in_prev_q, msb_in_prev_d;
   logic [22:0]       lfsr_q, lfsr_d;
   logic              lfsr_clk_prev_q, lfsr_clk_prev_d;
   logic [WAVE_W-1:0] saw_q, saw_d, tri_q, tri_d, pulse_q, pulse_d, noise_q, noise_d;
   logic              tri_m;
   logic [WAVE_W-1:0] mux;
   logic [OUT_W-1:0]  voice_q, voice_d;
   logic              voice_valid_q, voice_valid_d;

   assign ctl_noise   = control[7];
   assign ctl_pulse   = control[6];
   assign ctl_saw     = control[5];
   assign ctl_tri     = control[4];
   assign ctl_test    = control[3];
   assign ctl_ring    = control[2];
   assign ctl_sync    = control[1];
   assign unused_gate = control[0];

   // Phase accumulator: test clears, falling edge of modulator MSB syncs, else add
   always_comb begin
      msb_in_prev_d = acc_msb_in;
      if (ctl_test) begin
         acc_d = '0;
      end else if (ctl_sync && msb_in_prev_q && !acc_msb_in) begin
         acc_d = '0;
      end else begin
         acc_d = acc_q + ACC_W'(frequency);
      end
   end

   // Waveform generators sampled from the current accumulator; noise LFSR clocked by acc bit
   always_comb begin
      tri_m           = ctl_saw ? 1'b0 : (ctl_ring ? acc_msb_in : acc_q[ACC_W-1]);
      saw_d           = acc_q[ACC_W-1 -: WAVE_W];
      tri_d           = acc_q[ACC_W-2 -: WAVE_W] ^ {WAVE_W{tri_m}};
      pulse_d         = {WAVE_W{acc_q[ACC_W-1 -: PW_W] > pulse_width}};
      lfsr_clk_prev_d = acc_q[ACC_W-5];
      lfsr_d          = lfsr_q;
      if (ctl_test) begin
         lfsr_d = 23'd1;
      end else if (acc_q[ACC_W-5] != lfsr_clk_prev_q) begin
         lfsr_d = {lfsr_q[21:0], lfsr_q[22] ^ lfsr_q[17]};
      end
      noise_d = lfsr_d[22 -: WAVE_W];
   end

   // Waveform combiner: OR or AND of the enabled waveforms, zero when none enabled
   always_comb begin
      mux = '0;
      if (COMBINE != 0) begin
         if (ctl_noise || ctl_pulse || ctl_saw || ctl_tri) begin
            mux = '1;
            if (ctl_noise) mux = mux & noise_q;
            if (ctl_pulse) mux = mux & pulse_q;
            if (ctl_saw)   mux = mux & saw_q;
            if (ctl_tri)   mux = mux & tri_q;
         end
      end else begin
         if (ctl_noise) mux = mux | noise_q;
         if (ctl_pulse) mux = mux | pulse_q;
         if (ctl_saw)   mux = mux | saw_q;
         if (ctl_tri)   mux = mux | tri_q;
      end
   end

   // Oscillator, waveform and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc_q           <= '0;
         msb_in_prev_q   <= 1'b0;
         lfsr_q          <= 23'd1;
         lfsr_clk_prev_q <= 1'b0;
         saw_q           <= '0;
         tri_q           <= '0;
         pulse_q         <= '0;
         noise_q         <= '0;
         voice_q         <= '0;
         voice_valid_q   <= 1'b0;
      end else begin
         acc_q           <= acc_d;
         msb_in_prev_q   <= msb_in_prev_d;
         lfsr_q          <= lfsr_d;
         lfsr_clk_prev_q <= lfsr_clk_prev_d;
         saw_q           <= saw_d;
         tri_q           <= tri_d;
         pulse_q         <= pulse_d;
         noise_q         <= noise_d;
         voice_q         <= voice_d;
         voice_valid_q   <= voice_valid_d;
      end
   end

   if (MUL_PAR != 0) begin : g_par
      // Single-cycle scaling: top OUT_W bits of mux * env every cycle
      always_comb begin
         voice_d       = OUT_W'((PROD_W'(mux) * PROD_W'(env)) >> (PROD_W - OUT_W));
         voice_valid_d = 1'b1;
      end
   end else begin : g_seq
      typedef enum logic [1:0] {LATCH, SHIFT, DONE} mul_state_t;

      mul_state_t        state_q, state_d;
      logic [WAVE_W-1:0] mcand_q, mcand_d;
      logic [PROD_W-1:0] prod_q, prod_d;
      logic [CNT_W-1:0]  cnt_q, cnt_d;
      logic [WAVE_W:0]   psum;

      // Multiplier state registers
      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            state_q <= LATCH;
            mcand_q <= '0;
            prod_q  <= '0;
            cnt_q   <= '0;
         end else begin
            state_q <= state_d;
            mcand_q <= mcand_d;
            prod_q  <= prod_d;
            cnt_q   <= cnt_d;
         end
      end

      // Shift-add: prod holds {partial sum, remaining multiplier bits}, shifted right each step
      always_comb begin
         state_d       = state_q;
         mcand_d       = mcand_q;
         prod_d        = prod_q;
         cnt_d         = cnt_q;
         voice_d       = voice_q;
         voice_valid_d = 1'b0;
         psum          = '0;
         case (state_q)
            LATCH: begin
               mcand_d = mux;
               prod_d  = {{WAVE_W{1'b0}}, env};
               cnt_d   = '0;
               state_d = SHIFT;
            end
            SHIFT: begin
               psum   = {1'b0, prod_q[PROD_W-1:ENV_W]} + (prod_q[0] ? {1'b0, mcand_q} : '0);
               prod_d = {psum, prod_q[ENV_W-1:1]};
               cnt_d  = cnt_q + 1'b1;
               if (cnt_q == CNT_W'(ENV_W - 1)) state_d = DONE;
            end
            DONE: begin
               voice_d       = prod_q[PROD_W-1 -: OUT_W];
               voice_valid_d = 1'b1;
               state_d       = LATCH;
            end
            default: state_d = LATCH;
         endcase
      end
   end

   assign acc_msb_out = acc_q[ACC_W-1];
   assign voice       = voice_q;
   assign voice_valid = voice_valid_q;

endmodule

// File: tb/tb_sid_voice_wide.sv
// Bench for sid_voice_wide: a sequential-multiplier OR-combine instance and a
// single-cycle AND-combine instance share stimulus and are checked every cycle
// against an arithmetic reference model.
module tb_sid_voice_wide;

   logic        clk = 1'b0;
   logic        rst;
   logic [15:0] frequency;
   logic [11:0] pulse_width;
   logic [7:0]  control;
   logic [7:0]  env;
   logic        acc_msb_in;
   logic        msb_out_a, msb_out_b, valid_a, valid_b;
   logic [11:0] voice_a, voice_b;

   int errors = 0;
   int checks = 0;

   // reference model state
   int unsigned m_acc, m_lfsr, m_saw, m_tri, m_pulse, m_noise;
   int unsigned m_lat, m_voice_a, m_voice_b, m_edges;
   bit          m_prev, m_lclk, m_valid_a, m_valid_b;

   always #5 clk = ~clk;

   sid_voice_wide #(.COMBINE(0), .MUL_PAR(0)) dut_a (
      .clk(clk), .rst(rst), .frequency(frequency), .pulse_width(pulse_width),
      .control(control), .env(env), .acc_msb_in(acc_msb_in),
      .acc_msb_out(msb_out_a), .voice(voice_a), .voice_valid(valid_a));

   sid_voice_wide #(.COMBINE(1), .MUL_PAR(1)) dut_b (
      .clk(clk), .rst(rst), .frequency(frequency), .pulse_width(pulse_width),
      .control(control), .env(env), .acc_msb_in(acc_msb_in),
      .acc_msb_out(msb_out_b), .voice(voice_b), .voice_valid(valid_b));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_acc = 0; m_lfsr = 1; m_saw = 0; m_tri = 0; m_pulse = 0; m_noise = 0;
      m_lat = 0; m_voice_a = 0; m_voice_b = 0; m_edges = 0;
      m_prev = 0; m_lclk = 0; m_valid_a = 0; m_valid_b = 0;
   endtask

   function automatic int unsigned mix(input bit and_mode);
      int unsigned w[4];
      int unsigned r;
      bit any;
      w = '{m_noise, m_pulse, m_saw, m_tri};
      r = and_mode ? 32'hFFF : 32'h0;
      any = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (control[7-i]) begin
            any = 1'b1;
            r = and_mode ? (r & w[i]) : (r | w[i]);
         end
      end
      return any ? r : 0;
   endfunction

   task automatic check_outputs();
      chk("voice_a", voice_a, m_voice_a);
      chk("valid_a", valid_a, m_valid_a);
      chk("voice_b", voice_b, m_voice_b);
      chk("valid_b", valid_b, m_valid_b);
      chk("msb_a", msb_out_a, (m_acc >> 23) & 1);
      chk("msb_b", msb_out_b, (m_acc >> 23) & 1);
   endtask

   // advance the model over one clock using the present inputs, then compare
   task automatic step();
      int unsigned ma, mb, top, nl, nacc;
      bit tm, tst;
      tst = control[3];
      ma = mix(1'b0);
      mb = mix(1'b1);
      if (m_edges % 10 == 0) m_lat = ma * env;
      if (m_edges % 10 == 9) begin
         m_voice_a = (m_lat >> 8) & 32'hFFF;
         m_valid_a = 1'b1;
      end else begin
         m_valid_a = 1'b0;
      end
      m_edges++;
      m_voice_b = ((mb * env) >> 8) & 32'hFFF;
      m_valid_b = 1'b1;

      top = (m_acc >> 12) & 32'hFFF;
      tm = control[5] ? 1'b0 : (control[2] ? acc_msb_in : m_acc[23]);
      m_saw   = top;
      m_tri   = ((m_acc >> 11) & 32'hFFF) ^ (tm ? 32'hFFF : 32'h0);
      m_pulse = (top > pulse_width) ? 32'hFFF : 32'h0;
      nl = m_lfsr;
      if (tst) nl = 1;
      else if (m_acc[19] != m_lclk)
         nl = ((m_lfsr << 1) & 32'h7FFFFF) | (((m_lfsr >> 22) ^ (m_lfsr >> 17)) & 1);
      m_lfsr  = nl;
      m_noise = (nl >> 11) & 32'hFFF;
      m_lclk  = m_acc[19];
      if (tst) nacc = 0;
      else if (control[1] && m_prev && !acc_msb_in) nacc = 0;
      else nacc = (m_acc + frequency) & 32'hFFFFFF;
      m_acc  = nacc;
      m_prev = acc_msb_in;

      @(posedge clk);
      #1;
      check_outputs();
   endtask

   initial begin
      int first_valid;
      rst = 1'b0;
      frequency = 16'h1000; pulse_width = 12'h000; control = 8'h20;
      env = 8'hFF; acc_msb_in = 1'b0;
      #2 rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_voice_a", voice_a, 0);
      chk("rst_valid_a", valid_a, 0);
      chk("rst_voice_b", voice_b, 0);
      chk("rst_valid_b", valid_b, 0);
      chk("rst_msb_a", msb_out_a, 0);
      rst = 1'b0;
      model_reset();

      // sawtooth ramp, multiplier cadence and accumulator wrap
      first_valid = 0;
      for (int k = 1; k <= 4096; k++) begin
         step();
         if (first_valid == 0 && valid_a === 1'b1) first_valid = k;
         if (k == 'h802) chk("saw800_voice", voice_b, 12'h7F8);
         if (k == 4095) chk("msb_before_wrap", msb_out_a, 1);
         if (k == 4096) chk("msb_after_wrap", msb_out_a, 0);
      end
      chk("first_valid_cycle", first_valid, 10);

      // pulse at threshold 0x800, then threshold all-ones
      control = 8'h40; pulse_width = 12'h800; env = 8'h80;
      for (int k = 1; k <= 4096; k++) begin
         step();
         if (k == 'hC00) chk("pulse_high", voice_b, 12'h7FF);
         if (k == 'h400) chk("pulse_low", voice_b, 12'h000);
      end
      pulse_width = 12'hFFF;
      for (int k = 1; k <= 25; k++) begin
         step();
         if (k > 3) chk("pulse_fff_zero", voice_b, 0);
      end

      // hard sync on modulator falling edge, with and without test
      control = 8'h22; frequency = 16'h7100; env = 8'hFF;
      for (int r = 0; r < 8; r++) begin
         if (r == 6) control = 8'h2A;
         acc_msb_in = 1'b1;
         repeat (20) step();
         acc_msb_in = 1'b0;
         repeat (20) step();
      end

      // test bit holds noise at zero, then noise runs off acc[19]
      control = 8'h88; frequency = 16'h1234;
      repeat (5) step();
      control = 8'h80; frequency = 16'h8000;
      repeat (400) step();

      // saw and tri combined (OR in dut_a, AND in dut_b)
      control = 8'h30; frequency = 16'h1000; env = 8'hFF;
      repeat (200) step();

      // reset in the middle of a sequential multiply
      for (int k = 0; k < 10 && (m_edges % 10) != 4; k++) step();
      rst = 1'b1;
      #1;
      chk("midrst_voice_a", voice_a, 0);
      chk("midrst_valid_a", valid_a, 0);
      chk("midrst_voice_b", voice_b, 0);
      @(posedge clk);
      #1;
      chk("midrst_hold_valid_a", valid_a, 0);
      rst = 1'b0;
      model_reset();
      repeat (30) step();

      // randomized segments
      for (int s = 0; s < 25; s++) begin
         control = 8'($urandom_range(0, 255));
         if ($urandom_range(0, 7) != 0) control[3] = 1'b0;
         frequency = 16'($urandom);
         case ($urandom_range(0, 3))
            0: pulse_width = 12'h000;
            1: pulse_width = 12'hFFF;
            default: pulse_width = 12'($urandom);
         endcase
         env = 8'($urandom);
         for (int k = 0; k < 60; k++) begin
            if ($urandom_range(0, 7) == 0) acc_msb_in = ~acc_msb_in;
            if ($urandom_range(0, 15) == 0) env = 8'($urandom);
            step();
         end
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/sid_voice_wide.md
Name: sid_voice_wide

Overview:
Parametrised next-generation SID voice: phase accumulator, sawtooth/triangle/pulse/noise generators, ring modulation, hard sync and envelope scaling, generalised in accumulator, waveform, pulse-width, envelope and output widths.
- New vs. first generation: selectable waveform combine mode (OR or AND), 12-bit pulse-width compare, selectable sequential or single-cycle envelope multiplier, and a voice_valid strobe.
- Envelope arrives on a port from an external ADSR instance.
- Sits between the register file/ADSR and the voice mixer. Three instances form the voice ring via acc_msb_in/acc_msb_out.

Parameters:
ACC_W, 24, phase accumulator width (≥ WAVE_W+2, ≥ 20)
FREQ_W, 16, frequency word width (≤ ACC_W)
WAVE_W, 12, waveform sample width (8..16)
PW_W, 12, pulse-width compare width (≤ ACC_W)
ENV_W, 8, envelope width
OUT_W, 12, voice output width (≤ WAVE_W+ENV_W)
COMBINE, 0, 0 = OR-combine enabled waveforms; 1 = AND-combine
MUL_PAR, 0, 0 = sequential shift-add multiplier; 1 = single-cycle multiplier

Ports:
clk  in  1  system clock
rst  in  1  reset, asynchronous, active-high
frequency  in  FREQ_W  phase increment per clk
pulse_width  in  PW_W  pulse threshold
control  in  8  [7] noise, [6] pulse, [5] saw, [4] tri, [3] test, [2] ringmod, [1] sync, [0] gate (unused here; routed to ADSR)
env  in  ENV_W  envelope value
acc_msb_in  in  1  accumulator MSB of the modulating voice
acc_msb_out  out  1  acc[ACC_W-1]
voice  out  OUT_W  scaled voice sample
voice_valid  out  1  one-cycle pulse when voice updates

Behaviour:
Reset (async, rst=1): all registers cleared.
- acc=0, msb_in_prev=0, lfsr=1, lfsr_clk_prev=0, waveform regs=0.
- Multiplier state = LATCH; voice=0, voice_valid=0, acc_msb_out=0.
- Asserting rst mid-multiply aborts; no valid is issued for the aborted product.

Accumulator: each clk, acc <= (acc + zero-extended frequency) mod 2^ACC_W. Priority: test=1 → acc<=0; else sync=1 with msb_in_prev=1 and acc_msb_in=0 (falling edge) → acc<=0; else add. msb_in_prev <= acc_msb_in every cycle, unconditionally.

Waveform regs: registered from the current acc, so they lag acc by 1 cycle.
- saw = acc[ACC_W-1 -: WAVE_W].
- tri = acc[ACC_W-2 -: WAVE_W] XOR {WAVE_W{m}}.
  - m = 0 if saw enabled.
  - Otherwise m = acc_msb_in if ringmod=1, else acc[ACC_W-1].
- pulse = {WAVE_W{acc[ACC_W-1 -: PW_W] > pulse_width}}.
  - pulse_width = all-ones → pulse always 0.
  - pulse_width = 0 → pulse 0 only when the top bits = 0.
- Noise: 23-bit LFSR.
  - Steps when acc[ACC_W-5] ≠ lfsr_clk_prev (either edge); lfsr <= {lfsr[21:0], lfsr[22]^lfsr[17]}. lfsr_clk_prev <= acc[ACC_W-5].
  - test=1 → lfsr<=1, overriding the step.
  - noise reg <= next-state lfsr[22 -: WAVE_W].

Mux (combinational from waveform regs):
- No waveform enabled → 0.
- COMBINE=0 → bitwise OR of enabled waveforms.
- COMBINE=1 → bitwise AND of enabled waveforms.

Multiplier: product P = mux × env, width WAVE_W+ENV_W. voice <= P[WAVE_W+ENV_W-1 -: OUT_W].
- MUL_PAR=1: every cycle, voice <= scaled mux×env; voice_valid is held 1 from the first cycle after reset release.
- MUL_PAR=0: FSM with states LATCH → SHIFT (ENV_W cycles) → DONE → LATCH.
  - LATCH: capture mux and env.
  - SHIFT: if multiplier LSB=1, add multiplicand to the upper partial; shift right 1.
  - DONE: update voice, voice_valid=1 for this cycle only.
  - Period ENV_W+2 cycles. Operand changes during SHIFT are ignored until the next LATCH.
- voice holds its value between updates.
- test bit does not stall the FSM.

Test Plan:
1. Hold rst 3 cycles then release with env=0xFF, control=0x20 → voice=0 and voice_valid=0 during reset; first voice_valid pulse on cycle 10 after release (MUL_PAR=0, ENV_W=8); pulses every 10 cycles thereafter.
2. frequency=0x1000, control=0x20, env=0xFF → saw increments by 1 per cycle; a latched saw=0x800 gives voice=0x7F8; at acc wrap 0xFFF000→0x000000, saw goes 0xFFF→0x000 and acc_msb_out falls.
3. frequency=0x1000, pulse_width=0x800, control=0x40, env=0x80 → voice=0x7FF while acc[23:12]>0x800, voice=0x000 otherwise; pulse_width=0xFFF → voice stays 0.
4. Hard sync: control=0x22, frequency=0x0100, drive acc_msb_in 1→0 → acc=0 on the following clk. Drive acc_msb_in 0→1 → no reset. With test=1 also set → acc=0 regardless.
5. Test bit: control=0x88 for 5 cycles → acc=0, lfsr=1, noise reg=0. Release with frequency=0x8000 → LFSR steps once per acc[19] toggle (every 16 cycles); first step gives lfsr=0x000002.
6. COMBINE=1, control=0x30, frequency=0x1000, env=0xFF → voice equals (saw AND tri) scaled. COMBINE=0 with the same stimulus → (saw OR tri) scaled. rst pulsed mid-SHIFT → voice=0 and no stale voice_valid.
